posicionador_navio: RTL and testbench

Ship-placement engine for the Batalha Naval board. It takes one placement request (player, row, column, orientation, length) from the game controller and checks it against the board border. It then reads the player's board rows from the board RAM to detect overlap with ships already placed. If both checks pass, it read-modify-writes the affected rows. It sits between the game FSM and the two per-player board memories, and drives their shared address, write-enable and write-data lines.

---
 rtl/posicionador_navio.sv | 208 ++++++++++++++++++++
 tb/tb_posicionador_navio.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/posicionador_navio.sv
// Ship-placement engine: border check, overlap check against the player's
// board RAM, then read-modify-write of every row the ship covers.
module posicionador_navio #(
  parameter int unsigned ROWS      = 10,
  parameter int unsigned COLS      = 10,
  parameter int unsigned CELL_W    = 4,
  parameter logic [3:0]  SHIP_CODE = 4'h1,
  parameter int unsigned MAX_LEN   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        player,
  input  logic [3:0]  row,
  input  logic [3:0]  col,
  input  logic        orient,
  input  logic [2:0]  length,
  input  logic [63:0] data_memoria_um,
  input  logic [63:0] data_memoria_dois,
  output logic [4:0]  addr_memoria,
  output logic        wren_p1,
  output logic        wren_p2,
  output logic [63:0] data_memoria_salvar,
  output logic        busy,
  output logic        done,
  output logic        conflitoBorda,
  output logic        conflitoMemoria
);

  localparam int unsigned WORD_W = 64;
  localparam int unsigned NCELL  = WORD_W / CELL_W;

  typedef enum logic [2:0] {
    IDLE, BORDA, LE, VERIFICA, GRAVA_LE, MODIFICA, GRAVA, FIM
  } state_t;

  state_t state_q, state_n;

  // Latched request
  logic       player_q, orient_q;
  logic [3:0] row_q, col_q;
  logic [2:0] len_q, r_q;
  logic       latch_en;

  // Row index and registered-output next values
  logic [2:0]        i_q, i_n, i_inc;
  logic [4:0]        addr_n;
  logic              wren_p1_n, wren_p2_n, busy_n, done_n;
  logic              borda_n, memoria_n;
  logic [WORD_W-1:0] data_n;

  // Derived datapath values
  logic [4:0]        row_ext, col_ext, len_ext, col_end, row_end;
  logic              border_fail, more_rows, hit;
  logic [3:0]        row_off;
  logic [4:0]        addr_row0, addr_inc;
  logic [WORD_W-1:0] rd_word, cell_mask, ship_fill, merged;

  assign row_ext   = {1'b0, row_q};
  assign col_ext   = {1'b0, col_q};
  assign len_ext   = {2'b00, len_q};
  assign col_end   = col_ext + len_ext;
  assign row_end   = row_ext + len_ext;

  assign border_fail = (row_ext >= 5'(ROWS)) || (col_ext >= 5'(COLS)) ||
                       (len_q == 3'd0) || (len_ext > 5'(MAX_LEN)) ||
                       (!orient_q && (col_end > 5'(COLS))) ||
                       ( orient_q && (row_end > 5'(ROWS)));

  assign i_inc     = i_q + 3'd1;
  assign more_rows = (i_inc < r_q);
  assign row_off   = orient_q ? {1'b0, i_inc} : 4'd0;
  assign addr_row0 = {1'b0, row_q};
  assign addr_inc  = {1'b0, 4'(row_q + row_off)};

  assign rd_word   = player_q ? data_memoria_dois : data_memoria_um;
  assign ship_fill = {NCELL{SHIP_CODE}};

  // Mask of the cells the ship covers within one row word
  always_comb begin
    cell_mask = '0;
    for (int c = 0; c < int'(NCELL); c++) begin
      if (orient_q ? (5'(c) == col_ext) : ((5'(c) >= col_ext) && (5'(c) < col_end)))
        cell_mask[c*CELL_W +: CELL_W] = {CELL_W{1'b1}};
    end
  end

  assign hit    = |(rd_word & cell_mask);
  assign merged = (rd_word & ~cell_mask) | (ship_fill & cell_mask);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q             <= IDLE;
      i_q                 <= 3'd0;
      addr_memoria        <= 5'd0;
      wren_p1             <= 1'b0;
      wren_p2             <= 1'b0;
      data_memoria_salvar <= '0;
      busy                <= 1'b0;
      done                <= 1'b0;
      conflitoBorda       <= 1'b0;
      conflitoMemoria     <= 1'b0;
    end else begin
      state_q             <= state_n;
      i_q                 <= i_n;
      addr_memoria        <= addr_n;
      wren_p1             <= wren_p1_n;
      wren_p2             <= wren_p2_n;
      data_memoria_salvar <= data_n;
      busy                <= busy_n;
      done                <= done_n;
      conflitoBorda       <= borda_n;
      conflitoMemoria     <= memoria_n;
    end
  end

  // Request capture on an accepted start
  always_ff @(posedge clk) begin
    if (!reset) begin
      player_q <= 1'b0;
      orient_q <= 1'b0;
      row_q    <= 4'd0;
      col_q    <= 4'd0;
      len_q    <= 3'd0;
      r_q      <= 3'd0;
    end else if (latch_en) begin
      player_q <= player;
      orient_q <= orient;
      row_q    <= row;
      col_q    <= col;
      len_q    <= length;
      r_q      <= orient ? length : 3'd1;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_n   = state_q;
    i_n       = i_q;
    addr_n    = addr_memoria;
    wren_p1_n = 1'b0;
    wren_p2_n = 1'b0;
    data_n    = '0;
    borda_n   = conflitoBorda;
    memoria_n = conflitoMemoria;
    latch_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n   = BORDA;
          latch_en  = 1'b1;
          borda_n   = 1'b0;
          memoria_n = 1'b0;
          i_n       = 3'd0;
        end
      end
      BORDA: begin
        if (border_fail) begin
          state_n = FIM;
          borda_n = 1'b1;
        end else begin
          state_n = LE;
          i_n     = 3'd0;
          addr_n  = addr_row0;
        end
      end
      LE: state_n = VERIFICA;
      VERIFICA: begin
        if (hit) begin
          state_n   = FIM;
          memoria_n = 1'b1;
        end else if (more_rows) begin
          state_n = LE;
          i_n     = i_inc;
          addr_n  = addr_inc;
        end else begin
          state_n = GRAVA_LE;
          i_n     = 3'd0;
          addr_n  = addr_row0;
        end
      end
      GRAVA_LE: state_n = MODIFICA;
      MODIFICA: begin
        state_n   = GRAVA;
        data_n    = merged;
        wren_p1_n = !player_q;
        wren_p2_n = player_q;
      end
      GRAVA: begin
        if (more_rows) begin
          state_n = GRAVA_LE;
          i_n     = i_inc;
          addr_n  = addr_inc;
        end else begin
          state_n = FIM;
        end
      end
      FIM: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    done_n = (state_n == FIM);
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_posicionador_navio.sv
// Scoreboard bench for posicionador_navio with two behavioural board RAMs.
module tb_posicionador_navio;

  logic        clk = 1'b0;
  logic        reset, start, player, orient;
  logic [3:0]  row, col;
  logic [2:0]  length;
  logic [63:0] data_memoria_um, data_memoria_dois, data_memoria_salvar;
  logic [4:0]  addr_memoria;
  logic        wren_p1, wren_p2, busy, done, conflitoBorda, conflitoMemoria;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;

  // Board RAMs and preload port
  logic [63:0] mem1 [0:31];
  logic [63:0] mem2 [0:31];
  logic        clr = 1'b1, pre_en = 1'b0, pre_p = 1'b0;
  logic [4:0]  pre_a = 5'd0;
  logic [63:0] pre_d = '0;

  typedef struct { logic p; logic [4:0] a; logic [63:0] d; } wr_t;
  typedef struct { int sc; int n; logic fb; logic fm; } cp_t;
  wr_t wq[$];
  cp_t cq[$];
  wr_t we;
  cp_t ce;

  posicionador_navio dut (
    .clk(clk), .reset(reset), .start(start), .player(player), .row(row), .col(col),
    .orient(orient), .length(length), .data_memoria_um(data_memoria_um),
    .data_memoria_dois(data_memoria_dois), .addr_memoria(addr_memoria),
    .wren_p1(wren_p1), .wren_p2(wren_p2), .data_memoria_salvar(data_memoria_salvar),
    .busy(busy), .done(done), .conflitoBorda(conflitoBorda), .conflitoMemoria(conflitoMemoria)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAMs: one-cycle read latency, write on wren
  always @(posedge clk) begin
    if (clr) begin
      for (int k = 0; k < 32; k++) begin
        mem1[k] <= '0;
        mem2[k] <= '0;
      end
    end else begin
      if (pre_en && !pre_p) mem1[pre_a] <= pre_d;
      if (pre_en &&  pre_p) mem2[pre_a] <= pre_d;
      if (wren_p1) mem1[addr_memoria] <= data_memoria_salvar;
      if (wren_p2) mem2[addr_memoria] <= data_memoria_salvar;
    end
    data_memoria_um   <= mem1[addr_memoria];
    data_memoria_dois <= mem2[addr_memoria];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: pops expected writes and completions as the DUT produces them
  always @(negedge clk) begin
    if (mon_en) begin
      if (wren_p1 || wren_p2) begin
        if (wq.size() == 0) begin
          chk("unexpected_wren", 1, 0);
        end else begin
          we = wq.pop_front();
          chk("wr_p1", wren_p1, !we.p);
          chk("wr_p2", wren_p2, we.p);
          chk("wr_addr", addr_memoria, we.a);
          chk("wr_data", data_memoria_salvar, we.d);
        end
      end else begin
        chk("idle_data", data_memoria_salvar, 0);
      end
      if (done) begin
        if (cq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          ce = cq.pop_front();
          chk("latency", cyc - ce.sc, ce.n);
          chk("flag_borda", conflitoBorda, ce.fb);
          chk("flag_memoria", conflitoMemoria, ce.fm);
        end
      end
    end
  end

  task automatic preload(input logic p, input int a, input logic [63:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_p = p; pre_a = 5'(a); pre_d = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  function automatic logic [63:0] rd_mem(input logic p, input int a);
    return p ? mem2[a] : mem1[a];
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_wren_p1"}, wren_p1, 0);
    chk({tag, "_wren_p2"}, wren_p2, 0);
    chk({tag, "_addr"}, addr_memoria, 0);
    chk({tag, "_data"}, data_memoria_salvar, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_borda"}, conflitoBorda, 0);
    chk({tag, "_memoria"}, conflitoMemoria, 0);
  endtask

  // Model the request, drive it, optionally inject a stray start, wait for done
  task automatic place(input logic p, input int r, input int c, input logic o,
                       input int l, input int spur);
    cp_t cp;
    int  rr, k, j, rowk, conflict_k;
    logic [63:0] w;
    cp.fb = (r >= 10) || (c >= 10) || (l == 0) || (l > 5) ||
            (!o && (c + l > 10)) || (o && (r + l > 10));
    cp.fm = 1'b0;
    if (cp.fb) begin
      cp.n = 2;
    end else begin
      rr = o ? l : 1;
      conflict_k = -1;
      for (k = 0; k < rr && conflict_k < 0; k++) begin
        rowk = r + (o ? k : 0);
        w = rd_mem(p, rowk);
        for (j = 0; j < 16; j++)
          if ((o ? (j == c) : (j >= c && j < c + l)) && (w[4*j +: 4] != 4'h0))
            conflict_k = k;
      end
      if (conflict_k >= 0) begin
        cp.fm = 1'b1;
        cp.n  = 2 + 2 * (conflict_k + 1);
      end else begin
        for (k = 0; k < rr; k++) begin
          rowk = r + (o ? k : 0);
          w = rd_mem(p, rowk);
          for (j = 0; j < 16; j++)
            if (o ? (j == c) : (j >= c && j < c + l)) w[4*j +: 4] = 4'h1;
          wq.push_back('{p: p, a: 5'(rowk), d: w});
        end
        cp.n = 5 * rr + 2;
      end
    end
    @(negedge clk);
    player = p; row = 4'(r); col = 4'(c); orient = o; length = 3'(l); start = 1'b1;
    cp.sc = cyc;
    cq.push_back(cp);
    @(negedge clk);
    start = 1'b0;
    player = ~p; row = 4'd0; col = 4'd0; orient = ~o; length = 3'd1;
    #1 chk("busy_rise", busy, 1);
    if (spur > 0) begin
      repeat (spur - 1) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (cq.size() != 0 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (cq.size() != 0) begin
      chk("done_timeout", 0, 1);
      cq.delete();
    end
    chk("writes_drained", wq.size(), 0);
    wq.delete();
    @(negedge clk);
    #1 chk("busy_fall", busy, 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; player = 1'b0; row = 4'd0; col = 4'd0;
    orient = 1'b0; length = 3'd0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    // Horizontal success and its written word
    place(1'b0, 2, 3, 1'b0, 3, 0);
    chk("mem1_row2", mem1[2], 64'h0000_0000_0011_1000);
    chk("mem2_row2_untouched", mem2[2], 64'h0);

    // Border cases
    place(1'b0, 0, 8, 1'b0, 3, 0);
    place(1'b0, 7, 0, 1'b1, 4, 0);
    place(1'b0, 6, 0, 1'b1, 4, 0);
    place(1'b0, 0, 7, 1'b0, 3, 0);
    place(1'b0, 10, 0, 1'b0, 1, 0);
    place(1'b0, 0, 10, 1'b0, 1, 0);
    place(1'b0, 0, 0, 1'b0, 0, 0);
    place(1'b0, 0, 0, 1'b1, 6, 0);

    // Vertical overlap on player 2
    preload(1'b1, 2, 64'h0000_0000_0010_0000);
    place(1'b1, 1, 5, 1'b1, 3, 0);
    chk("mem2_row1_kept", mem2[1], 64'h0);
    chk("mem2_row2_kept", mem2[2], 64'h0000_0000_0010_0000);
    chk("mem2_row3_kept", mem2[3], 64'h0);

    // Vertical success over partially filled rows
    preload(1'b1, 1, 64'h0000_0000_0000_1110);
    preload(1'b1, 2, 64'h0000_0000_0000_1110);
    preload(1'b1, 3, 64'h0000_0000_0000_1110);
    place(1'b1, 1, 0, 1'b1, 3, 0);
    chk("mem2_row3_final", mem2[3], 64'h0000_0000_0000_1111);

    // Horizontal overlap at the first row
    place(1'b0, 2, 5, 1'b0, 2, 0);

    // Stray start while busy is ignored
    place(1'b0, 8, 2, 1'b1, 2, 4);
    place(1'b1, 5, 4, 1'b0, 4, 3);

    // Reset during the first GRAVA_LE of a vertical request
    @(negedge clk);
    player = 1'b0; row = 4'd4; col = 4'd9; orient = 1'b1; length = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #1 chk("gle_addr", addr_memoria, 4);
    reset = 1'b0;
    @(negedge clk);
    #1 check_all_zero("midreset");
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("midreset_no_write", mem1[4], 64'h0);

    // A few random requests
    for (int t = 0; t < 8; t++)
      place(1'($urandom_range(0, 1)), int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 6)), 0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
